uc_booth4: RTL and testbench

UC_BOOTH4 -- requirements
Module: uc_booth4

---
 rtl/uc_booth4.sv | 164 ++++++++++++++++
 tb/tb_uc_booth4.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_booth4.sv
// uc_booth4: control unit for a radix-4 Booth multiplier datapath.
// It sequences load, add/subtract, and 2-bit arithmetic shift over SIZE/2 iterations.
// Optional feature: define ZERO_SKIP_EN so that a zero triplet (000/111) shifts
// straight away in OP instead of spending an idle OP cycle before SHIFT.
module uc_booth4 #(
    parameter int SIZE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic q1,
    input  logic q0,
    input  logic q_menos1,
    output logic Carga_QM,
    output logic Borra,
    output logic Carga_A,
    output logic MoM2,
    output logic Resta,
    output logic Desplaza_AQ,
    output logic ocupado,
    output logic fin
);

    localparam int unsigned CNT_W = $clog2(SIZE / 2) + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(SIZE / 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OP    = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             shift_q;
    logic [2:0]       trip;
    logic             in_op;
    logic             zero_trip;
    logic             dec_2m;
    logic             dec_sub;

    assign trip      = {q1, q0, q_menos1};
    assign in_op     = (state == OP);
    assign zero_trip = (trip == 3'b000) || (trip == 3'b111);
    assign cnt_inc   = cnt + CNT_W'(1);

    // Booth radix-4 triplet decode: select 2M and/or subtract.
    always_comb begin
        dec_2m  = 1'b0;
        dec_sub = 1'b0;
        case (trip)
            3'b011:  dec_2m = 1'b1;
            3'b100: begin
                dec_2m  = 1'b1;
                dec_sub = 1'b1;
            end
            3'b101,
            3'b110:  dec_sub = 1'b1;
            default: begin
                dec_2m  = 1'b0;
                dec_sub = 1'b0;
            end
        endcase
    end

    // Add/subtract strobes are only live in OP; MoM2/Resta are masked by Carga_A.
    assign Carga_A = in_op & ~zero_trip;
    assign MoM2    = Carga_A & dec_2m;
    assign Resta   = Carga_A & dec_sub;

`ifdef ZERO_SKIP_EN
    assign Desplaza_AQ = shift_q | (in_op & zero_trip);
`else
    assign Desplaza_AQ = shift_q;
`endif

    // State, iteration counter and registered state-based outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            Carga_QM <= 1'b0;
            Borra    <= 1'b0;
            shift_q  <= 1'b0;
            ocupado  <= 1'b0;
            fin      <= 1'b0;
        end else begin
            Carga_QM <= 1'b0;
            Borra    <= 1'b0;
            shift_q  <= 1'b0;
            case (state)
                IDLE: begin
                    fin <= 1'b0;
                    if (inicio) begin
                        state    <= LOAD;
                        Carga_QM <= 1'b1;
                        Borra    <= 1'b1;
                        ocupado  <= 1'b1;
                    end else begin
                        ocupado <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt     <= '0;
                    state   <= OP;
                    ocupado <= 1'b1;
                end
                OP: begin
`ifdef ZERO_SKIP_EN
                    if (zero_trip) begin
                        // The shift already happened this cycle via Desplaza_AQ.
                        cnt <= cnt_inc;
                        if (cnt_inc == HALF) begin
                            state   <= DONE;
                            ocupado <= 1'b0;
                            fin     <= 1'b1;
                        end else begin
                            state   <= OP;
                            ocupado <= 1'b1;
                        end
                    end else begin
                        state   <= SHIFT;
                        shift_q <= 1'b1;
                        ocupado <= 1'b1;
                    end
`else
                    state   <= SHIFT;
                    shift_q <= 1'b1;
                    ocupado <= 1'b1;
`endif
                end
                SHIFT: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == HALF) begin
                        state   <= DONE;
                        ocupado <= 1'b0;
                        fin     <= 1'b1;
                    end else begin
                        state   <= OP;
                        ocupado <= 1'b1;
                    end
                end
                DONE: begin
                    ocupado <= 1'b0;
                    if (!inicio) begin
                        state <= IDLE;
                        fin   <= 1'b0;
                    end else begin
                        fin <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ocupado <= 1'b0;
                    fin     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uc_booth4.sv
// Bench for uc_booth4 driving a behavioural radix-4 Booth datapath (SIZE=4).
module tb_uc_booth4;

    localparam int SIZE = 4;
    localparam int MAXC = 40;
`ifdef ZERO_SKIP_EN
    localparam int LAT_ZERO = 4;
    localparam bit SKIP     = 1'b1;
`else
    localparam int LAT_ZERO = 6;
    localparam bit SKIP     = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, inicio;
    logic q1, q0, q_menos1;
    logic Carga_QM, Borra, Carga_A, MoM2, Resta, Desplaza_AQ, ocupado, fin;

    // datapath state
    logic signed [SIZE+1:0] dp_a;
    logic signed [SIZE+1:0] dp_m;
    logic [SIZE-1:0]        dp_q;
    logic                   dp_qm1;
    logic signed [SIZE-1:0] opa, opb;
    logic                   force_en;
    logic [2:0]             force_trip;
    logic [2*SIZE-1:0]      dp_result;
    logic signed [SIZE+1:0] addend;

    logic [2*SIZE-1:0] sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uc_booth4 #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .inicio(inicio),
        .q1(q1), .q0(q0), .q_menos1(q_menos1),
        .Carga_QM(Carga_QM), .Borra(Borra), .Carga_A(Carga_A),
        .MoM2(MoM2), .Resta(Resta), .Desplaza_AQ(Desplaza_AQ),
        .ocupado(ocupado), .fin(fin)
    );

    assign {q1, q0, q_menos1} = force_en ? force_trip : {dp_q[1], dp_q[0], dp_qm1};
    assign dp_result = {dp_a[SIZE-1:0], dp_q};

    always_comb begin
        addend = MoM2 ? (dp_m <<< 1) : dp_m;
        if (Resta) addend = -addend;
    end

    // Behavioural Booth datapath: A:Q:q_menos1 with M sign-extended by two bits.
    always_ff @(posedge clk) begin
        if (reset || Borra) begin
            dp_a   <= '0;
            dp_qm1 <= 1'b0;
        end else if (Carga_A) begin
            dp_a <= dp_a + addend;
        end else if (Desplaza_AQ) begin
            dp_a   <= {dp_a[SIZE+1], dp_a[SIZE+1], dp_a[SIZE+1:2]};
            dp_q   <= {dp_a[1:0], dp_q[SIZE-1:2]};
            dp_qm1 <= dp_q[1];
        end
        if (Carga_QM) begin
            dp_m <= {opa[SIZE-1], opa[SIZE-1], opa};
            dp_q <= opb;
        end
    end

    // Runs one multiply; checks busy, product via scoreboard, optional latency and no-add.
    task automatic run_op(input int a, input int b, input int exp_lat,
                          input bit chk_no_add, input bit hold, input string name);
        int lat;
        bit ca_seen;
        bit busy_bad;
        logic [2*SIZE-1:0] exp;
        opa = SIZE'(a);
        opb = SIZE'(b);
        sb.push_back((2*SIZE)'(a * b));
        inicio = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        if (!hold) inicio = 1'b0;
        ca_seen = 1'b0;
        busy_bad = 1'b0;
        while (!fin && lat < MAXC) begin
            if (ocupado !== 1'b1) busy_bad = 1'b1;
            if (Carga_A === 1'b1) ca_seen = 1'b1;
            if (Carga_A === 1'b1 && Desplaza_AQ === 1'b1) busy_bad = 1'b1;
            @(posedge clk);
            lat++;
            #1;
        end
        vectors++;
        if (fin !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: fin=%b after %0d edges, required 1", name, fin, lat);
            void'(sb.pop_front());
            return;
        end
        vectors++;
        if (busy_bad) begin
            miscompares++;
            $display("FAIL %s busy: ocupado dropped or Carga_A/Desplaza_AQ overlapped, required ocupado=1 until done", name);
        end
        exp = sb.pop_front();
        vectors++;
        if (dp_result !== exp) begin
            miscompares++;
            $display("FAIL %s product: got %0d required %0d", name, dp_result, exp);
        end
        if (exp_lat > 0) begin
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d edges required %0d", name, lat, exp_lat);
            end
        end
        if (chk_no_add) begin
            vectors++;
            if (ca_seen !== 1'b0) begin
                miscompares++;
                $display("FAIL %s no_add: Carga_A seen=%b required 0", name, ca_seen);
            end
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            vectors++;
            if (fin !== 1'b0 || ocupado !== 1'b0) begin
                miscompares++;
                $display("FAIL %s return_idle: fin=%b ocupado=%b required 0 0", name, fin, ocupado);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inicio = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if ({Carga_QM, Borra, Carga_A, MoM2, Resta, Desplaza_AQ, ocupado, fin} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {Carga_QM, Borra, Carga_A, MoM2, Resta, Desplaza_AQ, ocupado, fin});
        end
        inicio = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        opa = 4'sd2;
        opb = 4'sd1;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        vectors++;
        if ({Carga_QM, Borra, ocupado, Desplaza_AQ, fin} !== 5'b11100) begin
            miscompares++;
            $display("FAIL load_outputs: got %b required 11100", {Carga_QM, Borra, ocupado, Desplaza_AQ, fin});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({Carga_QM, Borra} !== 2'b00) begin
            miscompares++;
            $display("FAIL load_one_cycle: Carga_QM,Borra=%b required 00", {Carga_QM, Borra});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_products();
        run_op(3, 5, 6, 1'b0, 1'b0, "mul_3x5");
        run_op(-8, -8, 0, 1'b0, 1'b0, "mul_m8xm8");
        run_op(7, 0, LAT_ZERO, 1'b1, 1'b0, "mul_7x0");
        run_op(-5, 6, 0, 1'b0, 1'b0, "mul_m5x6");
        run_op(7, -8, 0, 1'b0, 1'b0, "mul_7xm8");
        for (int i = 0; i < 6; i++) begin
            run_op($urandom_range(15) - 8, $urandom_range(15) - 8, 0, 1'b0, 1'b0, "mul_rand");
        end
    endtask

    task automatic test_forced();
        force_en = 1'b1;
        force_trip = 3'b100;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({Carga_A, MoM2, Resta, Desplaza_AQ} !== 4'b1110) begin
            miscompares++;
            $display("FAIL forced_100: Carga_A,MoM2,Resta,Desplaza_AQ=%b required 1110",
                     {Carga_A, MoM2, Resta, Desplaza_AQ});
        end
        force_trip = 3'b111;
        #1;
        vectors++;
        if ({Carga_A, MoM2, Resta, Desplaza_AQ} !== {3'b000, SKIP}) begin
            miscompares++;
            $display("FAIL forced_111: Carga_A,MoM2,Resta,Desplaza_AQ=%b required %b",
                     {Carga_A, MoM2, Resta, Desplaza_AQ}, {3'b000, SKIP});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_en = 1'b0;
    endtask

    task automatic test_reset_in_shift();
        int n;
        opa = 4'sd3;
        opb = 4'sd5;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        n = 0;
        while (Desplaza_AQ !== 1'b1 && n < MAXC) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (Desplaza_AQ !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_shift: Desplaza_AQ=%b required 1 within %0d cycles", Desplaza_AQ, MAXC);
        end
        reset = 1'b1;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        inicio = 1'b0;
        vectors++;
        if ({Carga_QM, Borra, Carga_A, MoM2, Resta, Desplaza_AQ, ocupado, fin} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_op: got %b required 00000000",
                     {Carga_QM, Borra, Carga_A, MoM2, Resta, Desplaza_AQ, ocupado, fin});
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ocupado !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: ocupado=%b required 0", ocupado);
        end
        run_op(-3, 5, 0, 1'b0, 1'b0, "mul_after_reset");
    endtask

    task automatic test_hold_after_fin();
        logic [2*SIZE-1:0] res;
        run_op(2, -7, 0, 1'b0, 1'b1, "mul_hold");
        res = dp_result;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({fin, ocupado, Carga_QM} !== 3'b100 || dp_result !== res) begin
                miscompares++;
                $display("FAIL hold_done: fin,ocupado,Carga_QM=%b required 100, result %0d required %0d",
                         {fin, ocupado, Carga_QM}, dp_result, res);
            end
        end
        inicio = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({fin, ocupado} !== 2'b00) begin
            miscompares++;
            $display("FAIL release_done: fin,ocupado=%b required 00", {fin, ocupado});
        end
    endtask

    initial begin
        reset = 1'b1;
        inicio = 1'b0;
        force_en = 1'b0;
        force_trip = 3'b000;
        opa = '0;
        opb = '0;
        test_reset();
        test_load();
        test_products();
        test_forced();
        test_reset_in_shift();
        test_hold_after_fin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
